uart_fsm_rx: RTL and testbench

Serial receiver paired with the UART transmitter, consuming its `data_out` line. It synchronises the asynchronous serial input and detects 8N1 frames (start, 8 data bits LSB-first, one stop). It samples each bit at mid-period and presents each received byte on a valid/ack handshake to the downstream logic. Bit timing uses the same formula as the transmitter, so a loopback of TX into RX is bit-exact.

---
 rtl/uart_fsm_rx.sv | 148 ++++++++++++++
 tb/tb_uart_fsm_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fsm_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// valid/ack output register with frame-error and overrun pulses.
module uart_fsm_rx #(
  parameter int baud        = 9_600,
  parameter int clock_speed = 16_000_000
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  // Same bit-time formula as the transmitter so loopback is bit-exact.
  localparam int BIT_WIDTH  = (clock_speed / baud) / 2;
  localparam int HALF_WIDTH = BIT_WIDTH / 2;
  localparam int CNT_W      = $clog2(BIT_WIDTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]       sync_q;
  logic             rxs;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A good frame completing in the same cycle overrides this clear below.
    if (valid_q && rx_ack) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
            if (!valid_q || rx_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        // Held-low line must go idle before a new start can be seen.
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_fsm_rx.sv
// Directed bench for uart_fsm_rx: table of frames plus glitch and
// mid-frame reset sequences, all checked against hand-derived values.
module tb_uart_fsm_rx;

  localparam int BAUD   = 9_600;
  localparam int CLK_HZ = 16_000_000;
  localparam int BW     = (CLK_HZ / BAUD) / 2;
  localparam int HW     = BW / 2;
  // Start driven before posedge 1; rxs low after posedge 2; T0 is posedge 3.
  localparam int S_OFF  = 3 + HW + 9 * BW;

  localparam int ACK_NONE = 0;
  localparam int ACK_AUTO = 1;
  localparam int ACK_COIN = 2;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         ack_mode;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_rise;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       CLR_n;
  logic       rx_in;
  logic       rx_ack;
  logic       man_ack;
  logic       auto_ack = 1'b0;
  logic       auto_en;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_at_cyc = -1;

  logic       prev_valid = 1'b0;
  int         rise_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int         rise_cyc = 0, fall_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  logic [7:0] rise_data = 8'h00;

  vec_t vecs[8];

  uart_fsm_rx #(.baud(BAUD), .clock_speed(CLK_HZ)) dut (
    .clk       (clk),
    .CLR_n     (CLR_n),
    .rx_in     (rx_in),
    .rx_ack    (rx_ack),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rx_ack = man_ack | auto_ack;

  // Event monitor; auto-ack answers a fresh rx_valid one cycle later.
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) begin
      rise_cnt  <= rise_cnt + 1;
      rise_cyc  <= cyc;
      rise_data <= data_out;
    end
    if (!rx_valid && prev_valid) fall_cyc <= cyc;
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    auto_ack <= auto_en && rx_valid && !auto_ack;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    man_ack = (cyc == ack_at_cyc);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int r0, f0, o0, c0;
    r0 = rise_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    auto_en = (v.ack_mode == ACK_AUTO);
    c0 = cyc;
    ack_at_cyc = (v.ack_mode == ACK_COIN) ? c0 + S_OFF - 1 : -1;
    rx_in = 1'b0;
    repeat (BW) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = v.data[i];
      repeat (BW) tick();
    end
    rx_in = v.stop;
    repeat (BW) tick();
    repeat (v.hold_low) tick();
    rx_in = 1'b1;
    repeat (v.gap) tick();
    ack_at_cyc = -1;

    check({tag, " data_out"}, int'(data_out), int'(v.exp_data));
    check({tag, " rx_valid"}, int'(rx_valid), int'(v.exp_valid));
    check({tag, " rises"}, rise_cnt - r0, v.exp_rise);
    check({tag, " frame_err pulses"}, fe_cnt - f0, v.exp_fe);
    check({tag, " overrun pulses"}, ov_cnt - o0, v.exp_ov);
    if (v.exp_rise == 1) begin
      check({tag, " valid latency"}, rise_cyc - c0, S_OFF);
      check({tag, " byte at rise"}, int'(rise_data), int'(v.exp_data));
      if (v.ack_mode == ACK_AUTO) check({tag, " ack clear"}, fall_cyc - rise_cyc, 1);
    end
    if (v.exp_fe == 1) check({tag, " frame_err time"}, fe_cyc - c0, S_OFF);
    if (v.exp_ov == 1) check({tag, " overrun time"}, ov_cyc - c0, S_OFF);
    $display("frame %s: sent 0x%02h stop=%0b -> data_out=0x%02h rx_valid=%0b", tag, v.data, v.stop,
             data_out, rx_valid);
  endtask

  initial begin
    int r0, f0, o0;
    vec_t cv;

    //          data   stop  hold  ack       gap  exp    valid rise fe ov
    vecs[0] = '{8'hA5, 1'b1, 0,    ACK_AUTO, 20, 8'hA5, 1'b0, 1,   0, 0};
    vecs[1] = '{8'h3C, 1'b0, 5000, ACK_AUTO, 20, 8'hA5, 1'b0, 0,   1, 0};
    vecs[2] = '{8'h81, 1'b1, 0,    ACK_AUTO, 20, 8'h81, 1'b0, 1,   0, 0};
    vecs[3] = '{8'h01, 1'b1, 0,    ACK_AUTO, 0,  8'h01, 1'b0, 1,   0, 0};
    vecs[4] = '{8'hFE, 1'b1, 0,    ACK_AUTO, 20, 8'hFE, 1'b0, 1,   0, 0};
    vecs[5] = '{8'h11, 1'b1, 0,    ACK_NONE, 20, 8'h11, 1'b1, 1,   0, 0};
    vecs[6] = '{8'h22, 1'b1, 0,    ACK_NONE, 20, 8'h11, 1'b1, 0,   0, 1};
    vecs[7] = '{8'h33, 1'b1, 0,    ACK_COIN, 20, 8'h33, 1'b1, 0,   0, 0};

    CLR_n   = 1'b0;
    rx_in   = 1'b1;
    man_ack = 1'b0;
    auto_en = 1'b0;
    repeat (3) tick();
    check("reset data_out", int'(data_out), 0);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    CLR_n = 1'b1;
    repeat (10) tick();

    // Short low glitch: start sample finds the line high again.
    r0 = rise_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    rx_in = 1'b0;
    repeat (300) tick();
    rx_in = 1'b1;
    repeat (1000) tick();
    check("glitch rx_valid", int'(rx_valid), 0);
    check("glitch rises", rise_cnt - r0, 0);
    check("glitch frame_err pulses", fe_cnt - f0, 0);
    check("glitch overrun pulses", ov_cnt - o0, 0);
    $display("glitch: 300-clock low pulse -> rx_valid=%0b", rx_valid);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of the data bits of 0x55 while 0x33 is still valid.
    r0 = rise_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    auto_en = 1'b0;
    cv.data = 8'h55;
    rx_in = 1'b0;
    repeat (BW) tick();
    for (int i = 0; i < 3; i++) begin
      rx_in = cv.data[i];
      repeat (BW) tick();
    end
    CLR_n = 1'b0;
    #1;
    check("midreset data_out", int'(data_out), 0);
    check("midreset rx_valid", int'(rx_valid), 0);
    check("midreset frame_err", int'(frame_err), 0);
    check("midreset overrun", int'(overrun), 0);
    rx_in = 1'b1;
    repeat (5) tick();
    CLR_n = 1'b1;
    repeat (20) tick();
    check("midreset rises", rise_cnt - r0, 0);
    check("midreset frame_err pulses", fe_cnt - f0, 0);
    check("midreset overrun pulses", ov_cnt - o0, 0);
    $display("midreset: reset during 0x55 -> data_out=0x%02h rx_valid=%0b", data_out, rx_valid);

    cv = '{8'hC3, 1'b1, 0, ACK_AUTO, 20, 8'hC3, 1'b0, 1, 0, 0};
    run_vec(cv, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
